fetch_unit: RTL and testbench

Instruction fetch stage between the program counter and decode. Issues one instruction-memory read per PC value, with at most one request outstanding, and buffers returned words with their PC in a small FIFO. Presents buffered words to decode over a valid/ready handshake, and tells the PC when to advance. A branch flush discards buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, FIFO entry layout
// and the default address/instruction width.
package fetch_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the PC, instruction-memory and decode handshake signals around the
// fetch stage. The fetch unit sits on the master side; PC/memory/decode on slave.
interface fetch_if import fetch_pkg::*; #(
   parameter int XLEN = XLEN_DEFAULT
);

   logic [XLEN-1:0] pc;
   logic            pc_adv;
   logic            flush;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;

   modport master (
      input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
      output pc_adv, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
   );

   modport slave (
      output pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
      input  pc_adv, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small show-ahead FIFO holding fetched {pc, instr} entries. The head reads as
// zero while empty so decode never sees stale storage contents.
module fetch_fifo import fetch_pkg::*; #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   input  logic          clear,
   output entry_t        head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = empty ? '0 : mem[rd_ptr];

   // Storage array is written on push only; it carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time,
// returned words buffered with their PC, branch flush discards everything.
module fetch_unit import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int XLEN  = XLEN_DEFAULT
) (
   input  logic     clk,
   input  logic     rst_n,
   fetch_if.master  bus
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   fetch_state_t    state;
   logic [XLEN-1:0] pc_q;
   logic [CW-1:0]   count;
   logic [CW:0]     used;
   logic            full;
   logic            empty;
   logic            req;
   logic            grant;
   logic            push;
   logic            pop;
   logic            head_valid;
   entry_t          push_entry;
   entry_t          head;

   // An in-flight request already owns a FIFO slot, so it counts as used.
   assign used       = {1'b0, count} + {{CW{1'b0}}, (state != IDLE)};
   assign req        = rst_n & !bus.flush & (used < (CW+1)'(DEPTH)) &
                       ((state == IDLE) | ((state == WAIT) & bus.imem_rvalid));
   assign grant      = req & bus.imem_gnt;
   assign push       = rst_n & (state == WAIT) & bus.imem_rvalid & !bus.flush & !full;
   assign head_valid = rst_n & !empty & !bus.flush;
   assign pop        = head_valid & bus.dec_ready;
   assign push_entry = '{pc: pc_q, instr: bus.imem_rdata};

   assign bus.imem_req  = req;
   assign bus.imem_addr = bus.pc;
   assign bus.pc_adv    = grant;
   assign bus.dec_valid = head_valid;
   assign bus.dec_instr = head.instr;
   assign bus.dec_pc    = head.pc;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (bus.flush),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Request tracking FSM; pc_q remembers the address of the outstanding read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state <= WAIT;
                  pc_q  <= bus.pc;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (grant) begin
                     state <= WAIT;
                     pc_q  <= bus.pc;
                  end else begin
                     state <= IDLE;
                  end
               end else if (bus.flush) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (bus.imem_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC register model, a latency-configurable
// instruction memory model and a scoreboard of expected {pc, instr} entries.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   fetch_if #(.XLEN(XLEN)) bus ();

   fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int          checks;
   int          failures;
   int          cyc;
   int          pops;
   int          adv_count;
   int          mem_lat;
   exp_t        sb [$];
   int          mem_due [$];
   logic [31:0] mem_data [$];
   logic [31:0] pc_model;
   logic        obs_req;
   logic        obs_adv;
   logic        obs_valid;
   logic [31:0] obs_addr;
   logic [31:0] obs_pc;
   logic [31:0] obs_instr;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Drive one clock cycle of inputs, observe, update models, advance to next cycle.
   task automatic applyStimulus(input bit g, input bit fl, input logic [31:0] tgt,
                                input bit rdy, input bit rstn);
      exp_t        e;
      logic        granted;
      logic [31:0] pc_next;
      rst_n         = rstn;
      bus.imem_gnt  = g;
      bus.flush     = fl;
      bus.dec_ready = rdy;
      if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_data[0];
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = $urandom;
      end
      #2;
      obs_req   = bus.imem_req;
      obs_adv   = bus.pc_adv;
      obs_valid = bus.dec_valid;
      obs_addr  = bus.imem_addr;
      obs_pc    = bus.dec_pc;
      obs_instr = bus.dec_instr;
      granted   = (obs_req === 1'b1) && g;

      if (!rstn) begin
         checkOutput("rst_req_low", obs_req, 1'b0);
         checkOutput("rst_valid_low", obs_valid, 1'b0);
      end
      if (fl) begin
         checkOutput("flush_no_adv", obs_adv, 1'b0);
         checkOutput("flush_no_valid", obs_valid, 1'b0);
      end
      checkOutput("pc_adv_vs_grant", obs_adv, granted);
      if (obs_req === 1'b1) checkOutput("addr_eq_pc", obs_addr, pc_model);

      if (obs_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_valid", obs_valid, 1'b0);
         end else if (rdy) begin
            e = sb.pop_front();
            checkOutput("dec_pc", obs_pc, e.pc);
            checkOutput("dec_instr", obs_instr, e.instr);
            pops++;
         end
      end

      if (bus.imem_rvalid) begin
         void'(mem_due.pop_front());
         void'(mem_data.pop_front());
      end
      if (fl || !rstn) sb.delete();
      if (granted) begin
         adv_count++;
         mem_due.push_back(cyc + mem_lat);
         mem_data.push_back(pc_model ^ 32'hA5A5_0000);
         e.pc    = pc_model;
         e.instr = pc_model ^ 32'hA5A5_0000;
         sb.push_back(e);
      end

      pc_next = pc_model;
      if (fl) pc_next = tgt;
      else if (obs_adv === 1'b1) pc_next = pc_model + 32'd4;

      @(posedge clk);
      #1;
      cyc++;
      pc_model = pc_next;
      bus.pc   = pc_model;
   endtask

   task automatic drain();
      int n = 0;
      while ((mem_due.size() != 0 || sb.size() != 0) && n < 40) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n++;
      end
      checkOutput("drain_done", (mem_due.size() == 0 && sb.size() == 0), 1'b1);
   endtask

   task automatic doReset(input logic [31:0] start);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      pc_model = start;
      bus.pc   = start;
   endtask

   // Watchdog so the run always ends even if something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int p0;
      int a0;
      checks = 0; failures = 0; cyc = 0; pops = 0; adv_count = 0; mem_lat = 1;
      pc_model = 32'h0;
      bus.pc = 32'h0; bus.flush = 1'b0; bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.dec_ready = 1'b0;
      rst_n = 1'b0;

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("rst_dec_valid", obs_valid, 1'b0);
      checkOutput("rst_dec_pc", obs_pc, 32'h0);
      checkOutput("rst_dec_instr", obs_instr, 32'h0);
      checkOutput("rst_req_after", obs_req, 1'b1);
      checkOutput("rst_state", dut.state, IDLE);
      checkOutput("rst_count", dut.count, 0);

      $display("[TB] streaming, L=1");
      doReset(32'h0);
      p0 = pops;
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t1_throughput", pops - p0, 10);
      drain();

      $display("[TB] backpressure fills FIFO");
      doReset(32'h0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t2_buffered", sb.size(), 4);
      checkOutput("t2_count", dut.count, 4);
      checkOutput("t2_req_low", obs_req, 1'b0);
      checkOutput("t2_adv_low", obs_adv, 1'b0);
      checkOutput("t2_pc", pc_model, 32'h10);
      p0 = pops;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t2_no_req_on_pop", obs_req, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t2_resume_req", obs_req, 1'b1);
      checkOutput("t2_resume_addr", obs_addr, 32'h10);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t2_drain_pops", pops - p0, 8);
      drain();

      $display("[TB] grant withheld");
      doReset(32'h40);
      a0 = adv_count;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         checkOutput("t3_req_held", obs_req, 1'b1);
         checkOutput("t3_addr_held", obs_addr, 32'h40);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t3_adv_on_grant", obs_adv, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t3_adv_once", adv_count - a0, 1);
      drain();

      $display("[TB] flush while waiting, L=3");
      doReset(32'h20);
      mem_lat = 3;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
      checkOutput("t4_state_drop", dut.state, DROP);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t4_drop_no_req", obs_req, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t4_no_req_on_dropped_rsp", obs_req, 1'b0);
      checkOutput("t4_idle", dut.state, IDLE);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t4_next_req", obs_req, 1'b1);
      checkOutput("t4_next_addr", obs_addr, 32'h80);
      mem_lat = 1;
      drain();

      $display("[TB] flush coincident with response");
      doReset(32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t5_count2", dut.count, 2);
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
      checkOutput("t5_flush_count", dut.count, 0);
      checkOutput("t5_flush_idle", dut.state, IDLE);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t5_valid_after", obs_valid, 1'b0);
      checkOutput("t5_new_addr", obs_addr, 32'h100);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t5_first_valid", obs_valid, 1'b1);
      checkOutput("t5_first_pc", obs_pc, 32'h100);
      drain();

      $display("[TB] reset mid-operation");
      doReset(32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      mem_lat = 3;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t6_count3", dut.count, 3);
      checkOutput("t6_wait", dut.state, WAIT);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("t6_rst_idle", dut.state, IDLE);
      checkOutput("t6_rst_count", dut.count, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t6_stale_no_push", dut.count, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t6_stale_no_valid", obs_valid, 1'b0);
      mem_lat = 1;
      p0 = pops;
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("t6_recovered", pops - p0, 4);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
